reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Write-side initiator for the 16x8 two-read/one-write register file.
- Collects results from the ALU and the load unit through valid/ready handshakes and queues them in a DEPTH-entry in-order buffer.
- Drives the register file write port (we/dst/data) at one write per cycle.
- Offers combinational forwarding of pending, not-yet-committed writes to the two operand read addresses, so decode never reads stale data.

Parameters:
DATA_W, 8, register data width
ADDR_W, 4, register address width (16 registers, all writable, no hardwired zero)
DEPTH, 4, queue entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, width of occupancy count (derived, not overridable)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
alu_valid  input  1  ALU result valid
alu_ready  output  1  ALU result accepted this cycle when valid&ready
alu_dst  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
ld_valid  input  1  load result valid
ld_ready  output  1  load result accepted when valid&ready
ld_dst  input  ADDR_W  load destination register
ld_data  input  DATA_W  load data
hold  input  1  freeze write port (pipeline stall); no dequeue while high
wb_we  output  1  register file write enable (registered)
wb_dst  output  ADDR_W  register file write address (registered)
wb_data  output  DATA_W  register file write data (registered)
q_src0  input  ADDR_W  operand 0 lookup address
q_src1  input  ADDR_W  operand 1 lookup address
fwd_hit0  output  1  a pending write to q_src0 exists
fwd_data0  output  DATA_W  youngest pending data for q_src0
fwd_hit1  output  1  a pending write to q_src1 exists
fwd_data1  output  DATA_W  youngest pending data for q_src1
count  output  CNT_W  queue occupancy (excludes wb stage)

Behaviour:
- Reset (rst_n=0 at posedge): count=0, rd/wr pointers=0, wb_we=0, wb_dst=0, wb_data=0. All pending entries are discarded and never written. alu_ready=ld_ready=0 while rst_n=0.
- Acceptance:
  - At most one enqueue per cycle.
  - ld_ready = rst_n & (count<DEPTH).
  - alu_ready = rst_n & (count<DEPTH) & !ld_valid. Load has fixed priority.
  - Readiness uses registered count only; a same-cycle pop does not free space for a same-cycle push.
- Enqueue: entry {dst,data} is written at wr_ptr and wr_ptr increments mod DEPTH.
- Dequeue: at posedge, if count>0 and hold=0, the head loads into {wb_dst,wb_data}, wb_we<=1 and rd_ptr increments mod DEPTH. Otherwise wb_we<=0; wb_dst/wb_data hold their values.
- count update: push only +1; pop only -1; both 0.
- Latency: a handshake at edge E with an empty queue and hold=0 gives wb_we=1 during the cycle after edge E+1. The register file commits at edge E+2. wb_we is high for exactly one cycle per entry.
- Order: writes issue in acceptance order. Same-destination entries are never merged.
- Forwarding (combinational):
  - Search the valid queue entries and the wb stage (when wb_we=1).
  - fwd_hitK=1 if any dst==q_srcK.
  - fwd_dataK comes from the youngest match, with priority newest queue entry > older entries > wb stage.
  - With no hit, fwd_dataK=0.
  - An offer being handshaken in the current cycle is not visible until after the edge.
- hold mid-stream: the wb stage empties (wb_we=0) while queue contents stay forwardable. Pushes continue until full.
- Full (count=DEPTH): both readies 0. After the first pop edge, ready re-asserts.

Decomposition:
- Package cpu_pkg: DATA_W, ADDR_W, REG_COUNT=16 constants, and typedef wb_entry_t {dst[ADDR_W], data[DATA_W]} shared with the register file and pipeline.
- Sub-module wb_fifo: circular buffer holding pointers, count and storage. It exposes all entries plus per-entry valid bits and age order for the forwarding search.
- reg_writeback holds the arbitration, the wb output stage and the forwarding mux.

Test Plan:
- Single ALU write: alu dst=3, data=0x5A at edge E, hold=0 -> wb_we=1, wb_dst=3, wb_data=0x5A for one cycle after E+1. q_src0=3 gives fwd_hit0=1, fwd_data0=0x5A from after E until wb_we drops.
- Contention: ld(1,0x11) and alu(2,0x22) valid together -> alu_ready=0 that cycle. ld is accepted first, alu the next cycle. Writes issue dst 1 then dst 2 on consecutive cycles.
- Full/backpressure: hold=1, push 4 loads (4,0xA0..0xA3) -> count=4, ld_ready=0. Release hold -> four writes 0xA0..0xA3 on consecutive cycles. ld_ready=1 the cycle after the first pop.
- Youngest forward: hold=1, push (5,0x01) then (5,0x02), q_src1=5 -> fwd_hit1=1, fwd_data1=0x02. q_src0=6 -> fwd_hit0=0, fwd_data0=0.
- Reset mid-operation: 3 entries pending with hold=1, rst_n=0 for one edge -> count=0, wb_we stays 0 after release, fwd_hit0=fwd_hit1=0, no stale write ever issued.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the write-back entry type used by the
// register file, pipeline and write-back initiator.
package cpu_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int REG_COUNT = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of pending register writes. Every slot is exposed
// with a valid bit so the forwarding search can scan it by age from rd_ptr.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter  int DATA_W = cpu_pkg::DATA_W,
  parameter  int ADDR_W = cpu_pkg::ADDR_W,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_dst,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [CNT_W-1:0]  o_count,
  output logic [PTR_W-1:0]  o_rd_ptr,
  output logic [ADDR_W-1:0] o_ent_dst  [DEPTH],
  output logic [DATA_W-1:0] o_ent_data [DEPTH],
  output logic [DEPTH-1:0]  o_ent_vld
);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_dst  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is plain data; stale slots are masked by the valid bits.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_dst[r_wr_ptr]  <= i_push_dst;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PTR_W-1:0] w_age;
    assign w_age         = PTR_W'(g) - r_rd_ptr;
    assign o_ent_vld[g]  = {1'b0, w_age} < r_count;
    assign o_ent_dst[g]  = r_dst[g];
    assign o_ent_data[g] = r_data[g];
  end

  assign o_count  = r_count;
  assign o_rd_ptr = r_rd_ptr;

endmodule

// File: rtl/reg_writeback.sv
// Write-side initiator for the register file: arbitrates ALU/load results into
// an in-order queue, issues one registered write per cycle, forwards pending data.
module reg_writeback
  import cpu_pkg::*;
#(
  parameter  int DATA_W = cpu_pkg::DATA_W,
  parameter  int ADDR_W = cpu_pkg::ADDR_W,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_dst,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_dst,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              hold,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_dst,
  output logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] q_src0,
  input  logic [ADDR_W-1:0] q_src1,
  output logic              fwd_hit0,
  output logic [DATA_W-1:0] fwd_data0,
  output logic              fwd_hit1,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [CNT_W-1:0]  w_count;
  logic [PTR_W-1:0]  w_rd_ptr;
  logic [ADDR_W-1:0] w_ent_dst  [DEPTH];
  logic [DATA_W-1:0] w_ent_data [DEPTH];
  logic [DEPTH-1:0]  w_ent_vld;
  logic              w_space;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_push_dst;
  logic [DATA_W-1:0] w_push_data;

  function automatic logic [PTR_W-1:0] age_idx(input logic [PTR_W-1:0] base, input int age);
    return base + PTR_W'(age);
  endfunction

  // Readiness looks only at registered occupancy so a same-cycle pop never
  // opens a slot combinationally; load wins over ALU.
  assign w_space     = w_count < CNT_W'(DEPTH);
  assign ld_ready    = rst_n & w_space;
  assign alu_ready   = rst_n & w_space & ~ld_valid;
  assign w_push      = (ld_valid & ld_ready) | (alu_valid & alu_ready);
  assign w_push_dst  = ld_valid ? ld_dst  : alu_dst;
  assign w_push_data = ld_valid ? ld_data : alu_data;
  assign w_pop       = (w_count != '0) & ~hold;
  assign count       = w_count;

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_dst  (w_push_dst),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_rd_ptr    (w_rd_ptr),
    .o_ent_dst   (w_ent_dst),
    .o_ent_data  (w_ent_data),
    .o_ent_vld   (w_ent_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_we   <= 1'b0;
      wb_dst  <= '0;
      wb_data <= '0;
    end else if (w_pop) begin
      wb_we   <= 1'b1;
      wb_dst  <= w_ent_dst[w_rd_ptr];
      wb_data <= w_ent_data[w_rd_ptr];
    end else begin
      wb_we   <= 1'b0;
    end
  end

  // Scan oldest to youngest so the last match (newest write) wins; the wb
  // stage is older than every queued entry.
  always_comb begin
    fwd_hit0  = 1'b0;
    fwd_data0 = '0;
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    if (wb_we && wb_dst == q_src0) begin
      fwd_hit0  = 1'b1;
      fwd_data0 = wb_data;
    end
    if (wb_we && wb_dst == q_src1) begin
      fwd_hit1  = 1'b1;
      fwd_data1 = wb_data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (w_ent_vld[age_idx(w_rd_ptr, k)] && w_ent_dst[age_idx(w_rd_ptr, k)] == q_src0) begin
        fwd_hit0  = 1'b1;
        fwd_data0 = w_ent_data[age_idx(w_rd_ptr, k)];
      end
      if (w_ent_vld[age_idx(w_rd_ptr, k)] && w_ent_dst[age_idx(w_rd_ptr, k)] == q_src1) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = w_ent_data[age_idx(w_rd_ptr, k)];
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios then random traffic,
// compared every cycle against a queue-based reference model.
module tb_reg_writeback;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              alu_valid, alu_ready;
  logic [ADDR_W-1:0] alu_dst;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid, ld_ready;
  logic [ADDR_W-1:0] ld_dst;
  logic [DATA_W-1:0] ld_data;
  logic              hold;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_dst;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] q_src0, q_src1;
  logic              fwd_hit0, fwd_hit1;
  logic [DATA_W-1:0] fwd_data0, fwd_data1;
  logic [2:0]        count;

  always #5 clk = ~clk;

  reg_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dst(ld_dst), .ld_data(ld_data),
    .hold(hold), .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
    .q_src0(q_src0), .q_src1(q_src1),
    .fwd_hit0(fwd_hit0), .fwd_data0(fwd_data0), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .count(count)
  );

  typedef struct {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } ent_t;

  // Reference model: pending writes in acceptance order plus the write port.
  ent_t              mq[$];
  logic              m_we   = 1'b0;
  logic [ADDR_W-1:0] m_dst  = '0;
  logic [DATA_W-1:0] m_data = '0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fwd_model(input logic [ADDR_W-1:0] a, output logic hit, output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (m_we && m_dst == a) begin
      hit = 1'b1;
      d   = m_data;
    end
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].dst == a) begin
        hit = 1'b1;
        d   = mq[i].data;
      end
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    logic              sp;
    logic              h;
    logic [DATA_W-1:0] d;
    logic              pop;
    ent_t              e;
    #1;
    sp = rst_n && (mq.size() < DEPTH);
    chk("ld_ready",  32'(ld_ready),  32'(sp));
    chk("alu_ready", 32'(alu_ready), 32'(sp && !ld_valid));
    chk("count",     32'(count),     32'(mq.size()));
    fwd_model(q_src0, h, d);
    chk("fwd_hit0",  32'(fwd_hit0),  32'(h));
    chk("fwd_data0", 32'(fwd_data0), 32'(d));
    fwd_model(q_src1, h, d);
    chk("fwd_hit1",  32'(fwd_hit1),  32'(h));
    chk("fwd_data1", 32'(fwd_data1), 32'(d));
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_we   = 1'b0;
      m_dst  = '0;
      m_data = '0;
    end else begin
      pop = (mq.size() > 0) && !hold;
      if (pop) begin
        e      = mq.pop_front();
        m_we   = 1'b1;
        m_dst  = e.dst;
        m_data = e.data;
      end else begin
        m_we = 1'b0;
      end
      if (sp && ld_valid) begin
        e.dst = ld_dst; e.data = ld_data; mq.push_back(e);
      end else if (sp && alu_valid) begin
        e.dst = alu_dst; e.data = alu_data; mq.push_back(e);
      end
    end
    #1;
    chk("wb_we",   32'(wb_we),   32'(m_we));
    chk("wb_dst",  32'(wb_dst),  32'(m_dst));
    chk("wb_data", 32'(wb_data), 32'(m_data));
    @(negedge clk);
  endtask

  task automatic set_ld(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ld_valid = v; ld_dst = a; ld_data = d;
  endtask

  task automatic set_alu(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    alu_valid = v; alu_dst = a; alu_data = d;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; q_src0 = '0; q_src1 = '0;
    set_ld(1'b0, '0, '0);
    set_alu(1'b0, '0, '0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);

    // Reset state
    cycle();
    rst_n = 1'b1;
    cycle();

    // Single ALU write
    q_src0 = 4'd3; q_src1 = 4'd9;
    set_alu(1'b1, 4'd3, 8'h5A);
    cycle();
    set_alu(1'b0, '0, '0);
    cycle();
    chk("single_we",   32'(wb_we),     32'd1);
    chk("single_dst",  32'(wb_dst),    32'd3);
    chk("single_data", 32'(wb_data),   32'h5A);
    chk("single_fwd",  32'(fwd_data0), 32'h5A);
    cycle();
    chk("single_we_drop", 32'(wb_we), 32'd0);

    // Load/ALU contention
    q_src0 = 4'd1; q_src1 = 4'd2;
    set_ld(1'b1, 4'd1, 8'h11);
    set_alu(1'b1, 4'd2, 8'h22);
    cycle();
    set_ld(1'b0, '0, '0);
    cycle();
    set_alu(1'b0, '0, '0);
    for (int i = 0; i < 3; i++) cycle();

    // Full queue with backpressure, then drain
    hold = 1'b1; q_src0 = 4'd4;
    for (int i = 0; i < 4; i++) begin
      set_ld(1'b1, 4'd4, 8'hA0 + 8'(i));
      cycle();
    end
    chk("full_count", 32'(count),    32'd4);
    chk("full_ready", 32'(ld_ready), 32'd0);
    cycle();
    set_ld(1'b0, '0, '0);
    hold = 1'b0;
    for (int i = 0; i < 6; i++) cycle();

    // Youngest match wins
    hold = 1'b1; q_src0 = 4'd6; q_src1 = 4'd5;
    set_ld(1'b1, 4'd5, 8'h01);
    cycle();
    set_ld(1'b1, 4'd5, 8'h02);
    cycle();
    set_ld(1'b0, '0, '0);
    cycle();
    chk("young_hit1",  32'(fwd_hit1),  32'd1);
    chk("young_data1", 32'(fwd_data1), 32'h02);
    chk("young_hit0",  32'(fwd_hit0),  32'd0);
    hold = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Reset mid-operation discards pending writes
    hold = 1'b1; q_src0 = 4'd7; q_src1 = 4'd9;
    for (int i = 0; i < 3; i++) begin
      set_alu(1'b1, 4'd7 + 4'(i), 8'hC0 + 8'(i));
      cycle();
    end
    set_alu(1'b0, '0, '0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rst_no_write", 32'(wb_we), 32'd0);
    end
    chk("rst_hit0", 32'(fwd_hit0), 32'd0);
    chk("rst_hit1", 32'(fwd_hit1), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      hold  = ($urandom_range(0, 9) < 3);
      set_ld($urandom_range(0, 2) == 0, 4'($urandom_range(0, 7)), 8'($urandom));
      set_alu($urandom_range(0, 1) == 0, 4'($urandom_range(0, 7)), 8'($urandom));
      q_src0 = 4'($urandom_range(0, 7));
      q_src1 = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
